// File: rtl/seg_spinner_mux_if.sv
// Control and display-pin bundle for seg_spinner_mux.
// master drives the controls and observes the pins; slave is the driver core.
interface seg_spinner_mux_if #(
    parameter int NUM_DIGITS = 4
);
    logic                  enable;
    logic                  dir;
    logic                  mode;
    logic [7:0]            out;
    logic [NUM_DIGITS-1:0] anode;
    logic                  step_pulse;
    logic [4:0]            dbg_pos;

    modport master (
        output enable, dir, mode,
        input  out, anode, step_pulse, dbg_pos
    );

    modport slave (
        input  enable, dir, mode,
        output out, anode, step_pulse, dbg_pos
    );
endinterface

// File: rtl/seg_spinner_mux.sv
// Seven-segment spinner driver: step prescaler, position counter, digit scan,
// and two animations (per-digit spin, perimeter snake). Outputs are registered.
module seg_spinner_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 25_000_000,
    parameter int SCAN_DIV   = 50_000
) (
    input  logic               input_clock,
    input  logic               reset_n,
    seg_spinner_mux_if.slave   bus
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    // Snake position landmarks around the display outline.
    localparam logic [4:0] P_B      = 5'(NUM_DIGITS);
    localparam logic [4:0] P_C      = 5'(NUM_DIGITS + 1);
    localparam logic [4:0] P_D_LAST = 5'(2 * NUM_DIGITS + 1);
    localparam logic [4:0] P_E      = 5'(2 * NUM_DIGITS + 2);
    localparam logic [4:0] P_F      = 5'(2 * NUM_DIGITS + 3);
    localparam logic [4:0] LEN_1    = 5'(2 * NUM_DIGITS + 4);
    localparam logic [4:0] DIG_LAST = 5'(NUM_DIGITS - 1);

    logic                  r_mode_q;
    logic [4:0]            r_pos;
    logic [TW-1:0]         r_tick_cnt;
    logic [SW-1:0]         r_scan_cnt;
    logic [IW-1:0]         r_scan_idx;
    logic [7:0]            r_out;
    logic [NUM_DIGITS-1:0] r_anode;
    logic                  r_step;

    logic [4:0]            w_len;
    logic [4:0]            w_pos_next;
    logic [4:0]            w_idx5;
    logic [7:0]            w_pattern;
    logic [NUM_DIGITS-1:0] w_anode;

    assign w_len  = r_mode_q ? LEN_1 : 5'd6;
    assign w_idx5 = 5'(r_scan_idx);

    always_comb begin
        w_pos_next = r_pos;
        if (bus.dir) begin
            w_pos_next = (r_pos == 5'd0) ? (w_len - 5'd1) : (r_pos - 5'd1);
        end else begin
            w_pos_next = (r_pos == (w_len - 5'd1)) ? 5'd0 : (r_pos + 5'd1);
        end
    end

    // Segment bit numbering: [0]a [1]b [2]c [3]d [4]e [5]f; lit = 0.
    always_comb begin
        w_pattern = 8'hFF;
        if (!r_mode_q) begin
            case (r_pos)
                5'd0:    w_pattern[0] = 1'b0;
                5'd1:    w_pattern[5] = 1'b0;
                5'd2:    w_pattern[4] = 1'b0;
                5'd3:    w_pattern[3] = 1'b0;
                5'd4:    w_pattern[2] = 1'b0;
                5'd5:    w_pattern[1] = 1'b0;
                default: w_pattern = 8'hFF;
            endcase
        end else begin
            if (r_pos < P_B) begin
                if (w_idx5 == r_pos) w_pattern[0] = 1'b0;
            end else if (r_pos == P_B) begin
                if (w_idx5 == DIG_LAST) w_pattern[1] = 1'b0;
            end else if (r_pos == P_C) begin
                if (w_idx5 == DIG_LAST) w_pattern[2] = 1'b0;
            end else if (r_pos <= P_D_LAST) begin
                if (w_idx5 == (P_D_LAST - r_pos)) w_pattern[3] = 1'b0;
            end else if (r_pos == P_E) begin
                if (w_idx5 == 5'd0) w_pattern[4] = 1'b0;
            end else if (r_pos == P_F) begin
                if (w_idx5 == 5'd0) w_pattern[5] = 1'b0;
            end
        end
    end

    always_comb begin
        w_anode = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_anode[k] = (IW'(k) != r_scan_idx);
        end
    end

    always_ff @(posedge input_clock) begin
        if (!reset_n) begin
            r_mode_q   <= bus.mode;
            r_pos      <= 5'd0;
            r_tick_cnt <= '0;
            r_scan_cnt <= '0;
            r_scan_idx <= '0;
            r_out      <= 8'hFF;
            r_anode    <= '1;
            r_step     <= 1'b0;
        end else begin
            r_mode_q <= bus.mode;
            r_out    <= w_pattern;
            r_anode  <= w_anode;

            if (r_scan_cnt == SCAN_LAST) begin
                r_scan_cnt <= '0;
                r_scan_idx <= (r_scan_idx == IDX_LAST) ? '0 : r_scan_idx + 1'b1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end

            // A mode change restarts the animation and wins over a coincident tick.
            if (bus.mode != r_mode_q) begin
                r_pos      <= 5'd0;
                r_tick_cnt <= '0;
                r_step     <= 1'b0;
            end else if (bus.enable) begin
                if (r_tick_cnt == TICK_LAST) begin
                    r_tick_cnt <= '0;
                    r_pos      <= w_pos_next;
                    r_step     <= 1'b1;
                end else begin
                    r_tick_cnt <= r_tick_cnt + 1'b1;
                    r_step     <= 1'b0;
                end
            end else begin
                r_step <= 1'b0;
            end
        end
    end

    assign bus.out        = r_out;
    assign bus.anode      = r_anode;
    assign bus.step_pulse = r_step;
    assign bus.dbg_pos    = r_pos;
endmodule
